// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM slave with sized loads/stores and LATENCY wait states.
// Define DMEM_RESPONDER_ERR_EN to fault misaligned and out-of-range accesses instead of aligning/wrapping them.
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o
);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_n;
   logic [3:0] cnt;
   logic [31:0] mem [DEPTH];
   logic accept, fault, unused_addr;
   logic [1:0] lane;
   logic [IW-1:0] idx;
   logic [3:0] be;
   logic [31:0] wword, rword, ld;
   assign req_ready_o = state == IDLE;
   assign rsp_valid_o = state == RESP;
   assign accept = req_valid_i & req_ready_o;
   assign idx = req_addr_i[IW+1:2];
   assign unused_addr = ^req_addr_i;
`ifdef DMEM_RESPONDER_ERR_EN
   assign lane = req_addr_i[1:0];
   assign fault = req_size_i == 2'd3 || (req_size_i == 2'd1 && req_addr_i[0]) ||
                  (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0) ||
                  64'(req_addr_i) >= 64'(DEPTH) * 64'd4;
`else
   assign lane = req_size_i == 2'd2 ? 2'd0 : req_size_i == 2'd1 ? {req_addr_i[1], 1'b0} : req_addr_i[1:0];
   assign fault = req_size_i == 2'd3;
`endif
   assign be = req_size_i == 2'd2 ? 4'hF : req_size_i == 2'd1 ? 4'h3 << lane : 4'h1 << lane;
   assign wword = req_wdata_i << {lane, 3'b000};
   assign rword = mem[idx] >> {lane, 3'b000};
   assign ld = req_size_i == 2'd2 ? rword : req_size_i == 2'd1 ? {16'd0, rword[15:0]} : {24'd0, rword[7:0]};
   always_ff @(posedge clk_i)
      if (accept && req_we_i && !fault)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
   always_comb begin
      state_n = IDLE;
      case (state)
         IDLE: state_n = accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
         WAIT: state_n = cnt == 4'(LATENCY - 1) ? RESP : WAIT;
         RESP: state_n = rsp_ready_i ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   // response register is loaded only at accept, so later req_* activity cannot disturb it
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         cnt <= 4'd0;
         rsp_rdata_o <= 32'd0;
         rsp_err_o <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
         if (accept) begin
            rsp_rdata_o <= (fault || req_we_i) ? 32'd0 : ld;
            rsp_err_o <= fault;
         end else if (rsp_valid_o && rsp_ready_i) begin
            rsp_rdata_o <= 32'd0;
            rsp_err_o <= 1'b0;
         end
      end
   end
endmodule
